// File: rtl/axis_keygen_loader.sv
// axis_keygen_loader: ingest stage for the CGGI key generator.
// Splits one 64-bit AXI-Stream frame into parameter writes, secret-key BRAM
// writes and omega BRAM writes, then pulses load_done once the final omega
// word has been written.
module axis_keygen_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int N_PARAM    = 7,
  parameter int SK_LEN     = 1024,
  parameter int OMEGA_LEN  = 2145
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [63:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  core_ready,
  output logic                  param_we,
  output logic [3:0]            param_addr,
  output logic [63:0]           param_data,
  output logic                  sk_we,
  output logic [ADDR_WIDTH-1:0] sk_addr,
  output logic [DATA_WIDTH-1:0] sk_data,
  output logic                  om_we,
  output logic [ADDR_WIDTH-1:0] om_addr,
  output logic [DATA_WIDTH-1:0] om_data,
  output logic                  load_done,
  output logic                  busy,
  output logic                  err_len
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PARAM = 3'd1;
  localparam logic [2:0] S_SKEY  = 3'd2;
  localparam logic [2:0] S_OMEGA = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] PARAM_LAST = ADDR_WIDTH'(N_PARAM - 1);
  localparam logic [ADDR_WIDTH-1:0] SK_LAST    = ADDR_WIDTH'(SK_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] OM_LAST    = ADDR_WIDTH'(OMEGA_LEN - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  running_q;
  logic                  accept;
  logic                  wrParam, wrSk, wrOm;
  logic                  setErr, clrErr;

  logic                  paramWe_q;
  logic [3:0]            paramAddr_q;
  logic [63:0]           paramData_q;
  logic                  skWe_q;
  logic [ADDR_WIDTH-1:0] skAddr_q;
  logic [DATA_WIDTH-1:0] skData_q;
  logic                  omWe_q;
  logic [ADDR_WIDTH-1:0] omAddr_q;
  logic [DATA_WIDTH-1:0] omData_q;
  logic                  loadDone_q;
  logic                  errLen_q;

  // The key word lives in the upper half of each beat; the lower half is
  // only meaningful for parameter beats.
  logic [DATA_WIDTH-1:0] beatWord;
  assign beatWord = s_axis_tdata[63 -: DATA_WIDTH];

  // running_q keeps tready low while in reset and lets it follow core_ready
  // from the first clock edge after reset is released.
  assign s_axis_tready = running_q && core_ready && (state_q != S_DONE);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign busy          = (state_q == S_PARAM) || (state_q == S_SKEY) ||
                         (state_q == S_OMEGA);

  // Frame sequencing: decide the next state, counter value and which write
  // port (if any) this accepted beat goes to.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrParam = 1'b0;
    wrSk    = 1'b0;
    wrOm    = 1'b0;
    setErr  = 1'b0;
    clrErr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          clrErr = 1'b1;
          if (s_axis_tlast) begin
            setErr  = 1'b1;
            count_d = '0;
          end else begin
            wrParam = 1'b1;
            if (PARAM_LAST == '0) begin
              state_d = S_SKEY;
              count_d = '0;
            end else begin
              state_d = S_PARAM;
              count_d = ADDR_WIDTH'(1);
            end
          end
        end
      end
      S_PARAM: begin
        if (accept) begin
          if (s_axis_tlast) begin
            setErr  = 1'b1;
            state_d = S_IDLE;
            count_d = '0;
          end else begin
            wrParam = 1'b1;
            if (count_q == PARAM_LAST) begin
              state_d = S_SKEY;
              count_d = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
      end
      S_SKEY: begin
        if (accept) begin
          if (s_axis_tlast) begin
            setErr  = 1'b1;
            state_d = S_IDLE;
            count_d = '0;
          end else begin
            wrSk = 1'b1;
            if (count_q == SK_LAST) begin
              state_d = S_OMEGA;
              count_d = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
      end
      S_OMEGA: begin
        if (accept) begin
          if (count_q == OM_LAST) begin
            wrOm    = 1'b1;
            state_d = S_DONE;
            count_d = '0;
          end else if (s_axis_tlast) begin
            setErr  = 1'b1;
            state_d = S_IDLE;
            count_d = '0;
          end else begin
            wrOm    = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        count_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, beat counter and the post-reset enable for tready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= 1'b1;
    end
  end

  // Parameter port: strobe every beat, address/data only on a write so
  // they hold their last values in between.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      paramWe_q   <= 1'b0;
      paramAddr_q <= '0;
      paramData_q <= '0;
    end else begin
      paramWe_q <= wrParam;
      if (wrParam) begin
        paramAddr_q <= count_q[3:0];
        paramData_q <= s_axis_tdata;
      end
    end
  end

  // Secret-key BRAM port.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      skWe_q   <= 1'b0;
      skAddr_q <= '0;
      skData_q <= '0;
    end else begin
      skWe_q <= wrSk;
      if (wrSk) begin
        skAddr_q <= count_q;
        skData_q <= beatWord;
      end
    end
  end

  // Omega BRAM port.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      omWe_q   <= 1'b0;
      omAddr_q <= '0;
      omData_q <= '0;
    end else begin
      omWe_q <= wrOm;
      if (wrOm) begin
        omAddr_q <= count_q;
        omData_q <= beatWord;
      end
    end
  end

  // load_done follows the DONE cycle, i.e. one cycle after the last omega
  // write; err_len is sticky until the next frame's first accepted beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      loadDone_q <= 1'b0;
      errLen_q   <= 1'b0;
    end else begin
      loadDone_q <= (state_q == S_DONE);
      if (setErr) begin
        errLen_q <= 1'b1;
      end else if (clrErr) begin
        errLen_q <= 1'b0;
      end
    end
  end

  assign param_we   = paramWe_q;
  assign param_addr = paramAddr_q;
  assign param_data = paramData_q;
  assign sk_we      = skWe_q;
  assign sk_addr    = skAddr_q;
  assign sk_data    = skData_q;
  assign om_we      = omWe_q;
  assign om_addr    = omAddr_q;
  assign om_data    = omData_q;
  assign load_done  = loadDone_q;
  assign err_len    = errLen_q;

endmodule

// File: tb/tb_axis_keygen_loader.sv
// Testbench for axis_keygen_loader: directed frames with a write scoreboard.
module tb_axis_keygen_loader;

  localparam int N_PARAM   = 7;
  localparam int SK_LEN    = 1024;
  localparam int OMEGA_LEN = 2145;
  localparam int TIMEOUT   = 40;

  logic        aclk;
  logic        aresetn;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        core_ready;
  logic        param_we;
  logic [3:0]  param_addr;
  logic [63:0] param_data;
  logic        sk_we;
  logic [11:0] sk_addr;
  logic [31:0] sk_data;
  logic        om_we;
  logic [11:0] om_addr;
  logic [31:0] om_data;
  logic        load_done;
  logic        busy;
  logic        err_len;

  typedef struct {
    int          kind;
    int          addr;
    logic [63:0] data;
  } exp_t;

  exp_t expQ[$];
  int   checks     = 0;
  int   passes     = 0;
  int   loadSeen   = 0;
  int   loadExp    = 0;
  bit   prevLastOm = 0;

  axis_keygen_loader dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .core_ready    (core_ready),
    .param_we      (param_we),
    .param_addr    (param_addr),
    .param_data    (param_data),
    .sk_we         (sk_we),
    .sk_addr       (sk_addr),
    .sk_data       (sk_data),
    .om_we         (om_we),
    .om_addr       (om_addr),
    .om_data       (om_data),
    .load_done     (load_done),
    .busy          (busy),
    .err_len       (err_len)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input bit cond, input string name,
                             input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (cond) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Beat 0 of every frame is the fixed first parameter word; the rest encode
  // phase, frame and index so misrouted or reordered writes show up.
  function automatic logic [63:0] beatData(int fid, int phase, int idx);
    logic [31:0] hi;
    logic [31:0] lo;
    if (phase == 0 && idx == 0) return 64'h00400000_7FFFFFFF;
    hi = 32'((phase + 1) << 28) | 32'(fid << 20) | 32'(idx);
    lo = 32'hC0DE_0000 | 32'(idx);
    return {hi, lo};
  endfunction

  task automatic sendIdle(input int n);
    repeat (n) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      core_ready    = 1'b1;
    end
  endtask

  task automatic sendBeat(input logic [63:0] d, input bit last,
                          output int waits, output bit ok);
    waits = 0;
    ok    = 1'b0;
    while (!ok && waits < TIMEOUT) begin
      @(negedge aclk);
      core_ready    = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      #1;
      if (s_axis_tready) ok = 1'b1;
      else waits++;
    end
    if (!ok) checkOutput(1'b0, "beat_accept_timeout", 64'(waits), 64'(TIMEOUT));
  endtask

  task automatic checkAllZero(input string name);
    logic [199:0] v;
    v = {s_axis_tready, param_we, param_addr, param_data, sk_we, sk_addr, sk_data,
         om_we, om_addr, om_data, load_done, busy, err_len};
    checkOutput(v == '0, name, 64'(v != '0), 64'd0);
  endtask

  task automatic applyReset();
    sendIdle(1);
    #2;
    aresetn = 1'b0;
    #1;
    checkAllZero("reset_outputs_zero");
    checkOutput(expQ.size() == 0, "reset_queue_drained", 64'(expQ.size()), 64'd0);
    @(posedge aclk);
    #1;
    checkAllZero("reset_outputs_held");
    #2;
    aresetn = 1'b1;
    sendIdle(2);
    #1;
    checkOutput(s_axis_tready == 1'b1, "tready_after_reset", 64'(s_axis_tready), 64'd1);
  endtask

  // One frame; negative indices disable the corresponding feature.
  task automatic applyStimulus(input int fid, input int gapSk, input int gapOm,
                               input int stallOm, input int tlastSk, input int rstOm,
                               input bit b2b);
    int lens[3];
    int waits;
    bit ok;
    bit last;
    logic [63:0] d;
    exp_t e;
    lens[0] = N_PARAM;
    lens[1] = SK_LEN;
    lens[2] = OMEGA_LEN;
    for (int ph = 0; ph < 3; ph++) begin
      for (int idx = 0; idx < lens[ph]; idx++) begin
        d = beatData(fid, ph, idx);
        if ((ph == 1 && idx == gapSk) || (ph == 2 && idx == gapOm)) sendIdle(3);
        if (ph == 2 && idx == rstOm) begin
          applyReset();
          return;
        end
        if (ph == 2 && idx == stallOm) begin
          repeat (10) begin
            @(negedge aclk);
            core_ready    = 1'b0;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tlast  = 1'b0;
            #1;
            checkOutput(s_axis_tready == 1'b0, "stall_tready_low", 64'(s_axis_tready), 64'd0);
          end
        end
        last = (ph == 1 && idx == tlastSk) || (ph == 2 && idx == OMEGA_LEN - 1);
        sendBeat(d, last, waits, ok);
        if (!ok) return;
        if (b2b && ph == 0 && idx == 0)
          checkOutput(waits == 1, "b2b_done_gap", 64'(waits), 64'd1);
        if (ph == 1 && idx == tlastSk) begin
          sendIdle(1);
          #1;
          checkOutput(err_len == 1'b1, "err_len_set", 64'(err_len), 64'd1);
          checkOutput(busy == 1'b0, "err_back_to_idle", 64'(busy), 64'd0);
          return;
        end
        e.kind = ph;
        e.addr = idx;
        e.data = (ph == 0) ? d : {32'h0, d[63:32]};
        expQ.push_back(e);
      end
    end
    loadExp++;
  endtask

  // Monitor: pops the scoreboard on each write strobe and checks load_done
  // lands exactly one cycle after the final omega write.
  always @(negedge aclk) begin : monitor
    int          nS;
    int          kind;
    int          addr;
    logic [63:0] data;
    exp_t        e;
    if (!aresetn) begin
      prevLastOm = 1'b0;
    end else begin
      nS = int'(param_we) + int'(sk_we) + int'(om_we);
      if (nS > 1) checkOutput(1'b0, "strobe_onehot", 64'(nS), 64'd1);
      if (nS >= 1) begin
        if (param_we) begin
          kind = 0; addr = int'(param_addr); data = param_data;
        end else if (sk_we) begin
          kind = 1; addr = int'(sk_addr); data = {32'h0, sk_data};
        end else begin
          kind = 2; addr = int'(om_addr); data = {32'h0, om_data};
        end
        if (expQ.size() == 0) begin
          checkOutput(1'b0, "unexpected_write", 64'(addr), 64'(kind));
        end else begin
          e = expQ.pop_front();
          checkOutput(kind == e.kind, "write_port", 64'(kind), 64'(e.kind));
          checkOutput(addr == e.addr, "write_addr", 64'(addr), 64'(e.addr));
          checkOutput(data == e.data, "write_data", data, e.data);
        end
      end
      if (param_we && param_addr == 4'd0)
        checkOutput(err_len == 1'b0, "err_len_cleared", 64'(err_len), 64'd0);
      if (load_done || prevLastOm)
        checkOutput(load_done == prevLastOm, "load_done_timing", 64'(load_done), 64'(prevLastOm));
      if (load_done) loadSeen++;
      prevLastOm = om_we && (om_addr == 12'(OMEGA_LEN - 1));
    end
  end

  initial begin
    aresetn       = 1'b0;
    core_ready    = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    #12;
    checkAllZero("init_reset_zero");
    #11;
    aresetn = 1'b1;
    sendIdle(2);
    #1;
    checkOutput(s_axis_tready == 1'b1, "tready_follows_core", 64'(s_axis_tready), 64'd1);
    checkOutput(busy == 1'b0, "idle_not_busy", 64'(busy), 64'd0);

    applyStimulus(0, -1, -1, -1, -1, -1, 1'b0);
    sendIdle(3);
    applyStimulus(1, 500, 2144, -1, -1, -1, 1'b0);
    sendIdle(3);
    applyStimulus(2, -1, -1, 100, -1, -1, 1'b0);
    sendIdle(3);
    applyStimulus(3, -1, -1, -1, 10, -1, 1'b0);
    sendIdle(3);
    applyStimulus(4, -1, -1, -1, -1, -1, 1'b0);
    sendIdle(3);
    applyStimulus(5, -1, -1, -1, -1, 1000, 1'b0);
    sendIdle(3);
    applyStimulus(6, -1, -1, -1, -1, -1, 1'b0);
    applyStimulus(7, -1, -1, -1, -1, -1, 1'b1);
    sendIdle(6);
    #1;
    checkOutput(expQ.size() == 0, "scoreboard_empty", 64'(expQ.size()), 64'd0);
    checkOutput(loadSeen == loadExp, "load_done_count", 64'(loadSeen), 64'(loadExp));
    checkOutput(err_len == 1'b0, "final_err_len", 64'(err_len), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axis_keygen_loader.md
# axis_keygen_loader

Upstream ingest stage for the CGGI key generator. It accepts the 64-bit AXI-Stream configuration/data frame from the DMA and splits it into three write streams: parameter registers (7 beats), secret-key BRAM (SK_LEN beats) and omega BRAM (OMEGA_LEN beats). When the last omega word is written it pulses `load_done` so the key-generation core can start. It applies backpressure whenever the core is not ready to accept a new load.

## Interface
- `DATA_WIDTH`, 32: width of each key/omega word; taken from `s_axis_tdata[63:32]`.
- `ADDR_WIDTH`, 12: BRAM address width for the sk and omega ports.
- `N_PARAM`, 7: number of parameter beats at the start of each frame.
- `SK_LEN`, 1024: number of secret-key beats.
- `OMEGA_LEN`, 2145: number of omega beats.

Ports:
- `aclk` in 1: sole clock, rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 64: stream data.
- `s_axis_tvalid` in 1: stream valid.
- `s_axis_tlast` in 1: stream last.
- `s_axis_tready` out 1: stream ready.
- `core_ready` in 1: the core is idle and may be reloaded.
- `param_we` out 1: parameter write strobe.
- `param_addr` out 4: parameter index, 0..N_PARAM-1.
- `param_data` out 64: full beat.
- `sk_we` out 1: secret-key write strobe.
- `sk_addr` out ADDR_WIDTH: secret-key address.
- `sk_data` out DATA_WIDTH: `tdata[63:32]`.
- `om_we` out 1: omega write strobe.
- `om_addr` out ADDR_WIDTH: omega address.
- `om_data` out DATA_WIDTH: `tdata[63:32]`.
- `load_done` out 1: one-cycle pulse after the final omega write.
- `busy` out 1: high while in PARAM, SKEY or OMEGA.
- `err_len` out 1: sticky flag for an early `tlast`. It is cleared only by reset or by the first accepted beat of the next frame.

## Operation
- A beat is accepted when `s_axis_tvalid && s_axis_tready`.
- `s_axis_tready = core_ready && (state != DONE)`.
- States and transitions:
  - IDLE → PARAM on the first accepted beat. That beat is also parameter 0.
  - PARAM: beat k (k=0..N_PARAM-1) writes parameter k. On beat N_PARAM-1 go to SKEY.
  - SKEY: beat j writes `sk_addr=j`. On j=SK_LEN-1 go to OMEGA.
  - OMEGA: beat j writes `om_addr=j`. On j=OMEGA_LEN-1 go to DONE.
  - DONE: assert `load_done` for exactly one cycle, then go to IDLE.
- A single counter (width ≥ ADDR_WIDTH) is cleared on every state change and increments once per accepted beat.
- `tlast` handling:
  - On the final omega beat, `tlast` is ignored whether high or low.
  - On any earlier accepted beat, `tlast` sets `err_len`, suppresses the write of that beat, and returns the block to IDLE with no `load_done`.
- `s_axis_tdata[31:0]` is discarded in the SKEY and OMEGA states.
- No sign manipulation or arithmetic is applied to data; the loader passes data through only.
- `core_ready` falling mid-frame only stalls the frame (tready low). State and counter are held.

## Timing
- Write latency: strobe, address and data are registered, so they are valid on the cycle after acceptance.
- Exactly one strobe is high per accepted beat; at most one of `param_we`/`sk_we`/`om_we` is high in any cycle.
- Address and data hold their last values when the strobe is low.
- `load_done` is high in the cycle after the `om_we` for address OMEGA_LEN-1. That is 2 cycles after the final beat is accepted.
- `s_axis_tready` is low for exactly one cycle (DONE) between back-to-back frames.
- Sustained throughput is 1 beat/cycle with no bubbles inside a frame.
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE and the counter to 0.
  - All outputs go to 0: `s_axis_tready`, all strobes, addresses, data, `load_done`, `busy`, `err_len`.
  - After `aresetn` deasserts, `s_axis_tready` follows `core_ready` from the first rising edge onward.
  - A partially written frame is abandoned; the next accepted beat is parameter 0.

## Test plan
- **Nominal frame:** `core_ready=1`; send 7 params (beat0 = 0x00400000_7FFFFFFF), then 1024 sk words, then 2145 omega words, continuous valid, no tlast.
  - Required: 7 `param_we`, 1024 `sk_we` (addr 0..1023), 2145 `om_we` (addr 0..2144), data equal to `tdata[63:32]`.
  - Required: one `load_done` 2 cycles after the last beat; `err_len=0`.
- **Valid gaps:** deassert `tvalid` for 3 cycles at sk beat 500 and at omega beat 2144.
  - Required: addresses remain contiguous, no duplicate or missing strobe, and `load_done` arrives 2 cycles after the delayed last beat.
- **Backpressure:** drop `core_ready` for 10 cycles at omega beat 100.
  - Required: `tready=0` throughout, no strobes while stalled, and the resume writes `om_addr=100`.
- **Early tlast:** assert `tlast` on sk beat 10.
  - Required: no `sk_we` for that beat, `err_len=1`, no `load_done`.
  - Required: the next frame loads normally and clears `err_len` on its first beat.
- **Reset mid-frame:** pulse `aresetn` low asynchronously (between clock edges) at omega beat 1000.
  - Required: all outputs read 0 during reset; a new full frame then completes with `load_done`.
- **Back-to-back frames:** start the second frame immediately.
  - Required: one idle cycle with `tready=0` (DONE), then the second frame's beat0 is written to `param_addr=0`.
